// File: rtl/rsa_bridge_pkg.sv
// Shared constants and state encodings for the RSA-256 UART bridge.
package rsa_bridge_pkg;
  localparam logic [4:0] RX_ADDR    = 5'd0;
  localparam logic [4:0] TX_ADDR    = 5'd4;
  localparam logic [4:0] STAT_ADDR  = 5'd8;
  localparam int         RX_RDY_BIT = 7;
  localparam int         TX_RDY_BIT = 6;
  localparam int         IN_BYTES   = 32;
  localparam int         OUT_BYTES  = 31;

  typedef enum logic [2:0] {S_QRX, S_RX, S_START, S_WAIT, S_QTX, S_TX} state_e;
  typedef enum logic [1:0] {P_N, P_D, P_A} phase_e;
endpackage

// File: rtl/avm_byte_port.sv
// Single-outstanding Avalon-MM byte port: launches a transfer when idle,
// holds it through waitrequest, pulses done on the completing edge.
module avm_byte_port
  import rsa_bridge_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rd_req,
  input  logic        i_wr_req,
  input  logic [4:0]  i_addr,
  input  logic [7:0]  i_wdata,
  output logic        o_done,
  output logic [7:0]  o_rdata,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);
  logic       read_q, read_d, write_q, write_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       busy;
  logic       unused_rd_hi;

  assign busy         = read_q | write_q;
  assign o_done       = busy & ~avm_waitrequest;
  assign o_rdata      = avm_readdata[7:0];
  assign unused_rd_hi = ^avm_readdata[31:8];

  assign avm_address   = addr_q;
  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_writedata = {24'b0, wdata_q};

  // Request drops for one cycle after each completion before the next launch.
  always_comb begin
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (o_done) begin
      read_d  = 1'b0;
      write_d = 1'b0;
    end else if (!busy) begin
      read_d  = i_rd_req;
      write_d = i_wr_req & ~i_rd_req;
      addr_d  = i_addr;
      wdata_d = (i_wr_req & ~i_rd_req) ? i_wdata : 8'h00;
    end
  end

  // Reset state is the first status poll, so polling begins on release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      read_q  <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= STAT_ADDR;
      wdata_q <= 8'h00;
    end else begin
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: rtl/rsa256_uart_bridge.sv
// Loads N, d and ciphertext blocks from a polled UART, runs the RSA core,
// and streams the low 31 plaintext bytes back out.
module rsa256_uart_bridge
  import rsa_bridge_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  output logic [4:0]   avm_address,
  output logic         avm_read,
  input  logic [31:0]  avm_readdata,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  input  logic         avm_waitrequest,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_n,
  input  logic [255:0] i_core_result,
  input  logic         i_core_finished
);
  state_e         state_q, state_d;
  phase_e         phase_q, phase_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [255:0]   n_q, n_d, d_q, d_d, a_q, a_d;
  logic [247:0]   out_q, out_d;
  logic           rd_req, wr_req, done;
  logic [4:0]     req_addr;
  logic [7:0]     rdata;
  logic           unused_res_hi;

  assign unused_res_hi = ^i_core_result[255:248];
  assign o_core_n = n_q;
  assign o_core_d = d_q;
  assign o_core_a = a_q;

  avm_byte_port u_port (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_rd_req        (rd_req),
    .i_wr_req        (wr_req),
    .i_addr          (req_addr),
    .i_wdata         (out_q[247:240]),
    .o_done          (done),
    .o_rdata         (rdata),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    d_d          = d_q;
    a_d          = a_q;
    out_d        = out_q;
    rd_req       = 1'b0;
    wr_req       = 1'b0;
    req_addr     = STAT_ADDR;
    o_core_start = 1'b0;
    case (state_q)
      S_QRX: begin
        rd_req = 1'b1;
        if (done && rdata[RX_RDY_BIT]) state_d = S_RX;
      end
      S_RX: begin
        rd_req   = 1'b1;
        req_addr = RX_ADDR;
        if (done) begin
          case (phase_q)
            P_N:     n_d = {n_q[247:0], rdata};
            P_D:     d_d = {d_q[247:0], rdata};
            default: a_d = {a_q[247:0], rdata};
          endcase
          state_d = S_QRX;
          if (cnt_q == 5'(IN_BYTES - 1)) begin
            cnt_d = 5'd0;
            case (phase_q)
              P_N:     phase_d = P_D;
              P_D:     phase_d = P_A;
              default: state_d = S_START;
            endcase
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_START: begin
        o_core_start = 1'b1;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (i_core_finished) begin
          out_d   = i_core_result[247:0];
          cnt_d   = 5'd0;
          state_d = S_QTX;
        end
      end
      S_QTX: begin
        rd_req = 1'b1;
        if (done && rdata[TX_RDY_BIT]) state_d = S_TX;
      end
      S_TX: begin
        wr_req   = 1'b1;
        req_addr = TX_ADDR;
        if (done) begin
          out_d = {out_q[239:0], 8'h00};
          if (cnt_q == 5'(OUT_BYTES - 1)) begin
            cnt_d   = 5'd0;
            state_d = S_QRX;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = S_QTX;
          end
        end
      end
      default: state_d = S_QRX;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_QRX;
      phase_q <= P_N;
      cnt_q   <= 5'd0;
      n_q     <= '0;
      d_q     <= '0;
      a_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      d_q     <= d_d;
      a_q     <= a_d;
      out_q   <= out_d;
    end
  end
endmodule

// File: tb/tb_rsa256_uart_bridge.sv
// Directed bench: UART/Avalon slave model, fixed-latency core model, and a
// linear sequence of load / decrypt / transmit / reset scenarios.
module tb_rsa256_uart_bridge;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   avm_address;
  logic         avm_read, avm_write, avm_waitrequest;
  logic [31:0]  avm_readdata, avm_writedata;
  logic         o_core_start, i_core_finished;
  logic [255:0] o_core_a, o_core_d, o_core_n, res_val;

  always #5 clk = ~clk;

  rsa256_uart_bridge dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .o_core_start(o_core_start), .o_core_a(o_core_a), .o_core_d(o_core_d), .o_core_n(o_core_n),
    .i_core_result(res_val), .i_core_finished(i_core_finished)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // UART slave: byte queue, optional not-ready polls, fixed waitrequest stall
  logic [7:0] rxq [0:511];
  int rx_len = 0, rx_ptr = 0, nr_cnt = 0, nr_polls = 0, stall_n = 0, wcnt = 0;
  logic rx_rdy;
  assign rx_rdy = (rx_ptr < rx_len) && (nr_cnt >= nr_polls);
  assign avm_waitrequest = (avm_read || avm_write) && (wcnt < stall_n);

  always_comb begin
    avm_readdata = 32'hDEADBE00;
    if (avm_address == 5'd8)      avm_readdata = {24'h5A5A5A, rx_rdy, 1'b1, 6'b010101};
    else if (avm_address == 5'd0) avm_readdata = {24'hA5A5A5, rxq[rx_ptr]};
  end

  always @(posedge clk) begin
    if ((avm_read || avm_write) && avm_waitrequest) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (avm_read && !avm_waitrequest && avm_address == 5'd0) begin
      rx_ptr <= rx_ptr + 1;
      nr_cnt <= 0;
    end else if (avm_read && !avm_waitrequest && avm_address == 5'd8 && !rx_rdy) begin
      nr_cnt <= nr_cnt + 1;
    end
  end

  // Core model: finished pulse about 10 cycles after start, plus injectable spurious pulse
  int core_cnt = 0;
  logic spur = 1'b0;
  always @(posedge clk) begin
    if (o_core_start) core_cnt <= 10;
    else if (core_cnt != 0) core_cnt <= core_cnt - 1;
  end
  assign i_core_finished = (core_cnt == 1) || spur;

  // Bus monitor
  logic [7:0]  tx_log [0:127];
  int          tx_writes = 0, rx_reads = 0, starts = 0;
  logic        stall_pend = 1'b0, last_stat_rdy = 1'b0, prev_start = 1'b0;
  logic [38:0] saved_bus = '0;
  always @(negedge clk) begin
    if (stall_pend) chk("stall_hold", {avm_address, avm_read, avm_write, avm_writedata}, saved_bus);
    stall_pend <= (avm_read || avm_write) && avm_waitrequest;
    saved_bus  <= {avm_address, avm_read, avm_write, avm_writedata};
    if (avm_read || avm_write) chk("rd_wr_excl", avm_read & avm_write, 0);
    if ((avm_read || avm_write) && !avm_waitrequest) begin
      if (avm_write) begin
        chk("tx_addr", avm_address, 4);
        chk("tx_upper", avm_writedata[31:8], 0);
        tx_log[tx_writes] <= avm_writedata[7:0];
        tx_writes <= tx_writes + 1;
      end else if (avm_address == 5'd0) begin
        chk("rx_after_rdy", last_stat_rdy, 1);
        rx_reads <= rx_reads + 1;
      end else if (avm_address == 5'd8) begin
        last_stat_rdy <= avm_readdata[7];
      end
    end
    if (o_core_start) begin
      chk("start_width", prev_start, 0);
      starts <= starts + 1;
    end
    prev_start <= o_core_start;
  end

  // Operand byte streams: 0=N, 1=d, 2=a, 3=a (block 2), 4=N (after reset)
  function automatic logic [7:0] nb(input int i, input int sel);
    case (sel)
      0:       return (i == 0) ? 8'hCA : (i == 1) ? 8'h35 : 8'(i * 29 + 3);
      1:       return (i == 0) ? 8'hB6 : (i == 1) ? 8'hAC : 8'(i * 13 + 7);
      2:       return (i == 31) ? 8'h41 : 8'h00;
      3:       return (i == 0) ? 8'h99 : (i == 31) ? 8'h42 : 8'(i);
      default: return 8'(255 - i * 5);
    endcase
  endfunction

  function automatic logic [255:0] opv(input int sel);
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[255 - 8 * i -: 8] = nb(i, sel);
    return v;
  endfunction

  task automatic push_bytes(input int sel, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      rxq[rx_len] = nb(i, sel);
      rx_len++;
    end
  endtask

  task automatic wait_cnt(input int which, input int n, input int budget, input string tag);
    int c = 0;
    int cur = (which == 0) ? rx_reads : tx_writes;
    while (cur < n && c < budget) begin
      @(negedge clk);
      c++;
      cur = (which == 0) ? rx_reads : tx_writes;
    end
    chk(tag, cur, n);
  endtask

  task automatic chk_tx(input int base, input string tag);
    logic [247:0] got;
    for (int k = 0; k < 31; k++) got[247 - 8 * k -: 8] = tx_log[base + k];
    chk(tag, got, res_val[247:0]);
    chk({tag, "_tail"}, {tx_log[base + 25], tx_log[base + 26], tx_log[base + 27],
                         tx_log[base + 28], tx_log[base + 29], tx_log[base + 30]}, 48'h0048656C6C6F);
  endtask

  initial begin
    logic [255:0] pd;
    res_val = {8'hEE, 8'h11, 8'h22, 184'h0, 8'h00, 40'h48656C6C6F};
    repeat (2) @(negedge clk);
    chk("rst_addr", avm_address, 8);
    chk("rst_read", avm_read, 1);
    chk("rst_write", avm_write, 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_start", o_core_start, 0);
    chk("rst_ops", {o_core_n[0], |o_core_n, |o_core_d, |o_core_a}, 0);

    // Block 1 with a spurious finished pulse while operands are loading
    push_bytes(0, 32); push_bytes(1, 32); push_bytes(2, 32);
    rst_n = 1'b1;
    wait_cnt(0, 10, 500, "rx_reach10");
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (6) @(negedge clk);
    chk("spur_no_tx", tx_writes, 0);
    chk("spur_no_start", starts, 0);
    wait_cnt(1, 31, 5000, "tx_blk1_wait");
    repeat (30) @(negedge clk);
    chk("tx_blk1_cnt", tx_writes, 31);
    chk("rx_blk1_cnt", rx_reads, 96);
    chk("starts_blk1", starts, 1);
    chk("op_n", o_core_n, opv(0));
    chk("op_d", o_core_d, opv(1));
    chk("op_a", o_core_a, opv(2));
    chk_tx(0, "tx_blk1");

    // Block 2: only the ciphertext is fetched
    push_bytes(3, 32);
    wait_cnt(1, 62, 5000, "tx_blk2_wait");
    repeat (30) @(negedge clk);
    chk("tx_blk2_cnt", tx_writes, 62);
    chk("rx_blk2_cnt", rx_reads, 128);
    chk("starts_blk2", starts, 2);
    chk("op_n_kept", o_core_n, opv(0));
    chk("op_d_kept", o_core_d, opv(1));
    chk("op_a2", o_core_a, opv(3));
    chk_tx(31, "tx_blk2");

    // Fresh start, load N and 17 bytes of d, then reset asynchronously
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_bytes(0, 32); push_bytes(1, 17);
    wait_cnt(0, 177, 2000, "rx_mid_d");
    repeat (10) @(negedge clk);
    pd = '0;
    for (int i = 0; i < 17; i++) pd[8 * (16 - i) +: 8] = nb(i, 1);
    chk("mid_n", o_core_n, opv(0));
    chk("mid_d_partial", o_core_d, pd);
    chk("mid_a_zero", o_core_a, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_n", o_core_n, 0);
    chk("arst_d", o_core_d, 0);
    chk("arst_bus", {avm_address, avm_read, avm_write}, {5'd8, 1'b1, 1'b0});

    // Reload under 3-cycle waitrequest stalls and 50 not-ready polls per byte
    stall_n = 3; nr_polls = 50;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_bytes(4, 32); push_bytes(1, 32); push_bytes(2, 32);
    wait_cnt(0, 273, 40000, "rx_stall_wait");
    wait_cnt(1, 93, 5000, "tx_blk3_wait");
    repeat (30) @(negedge clk);
    chk("rx_stall_cnt", rx_reads, 273);
    chk("tx_blk3_cnt", tx_writes, 93);
    chk("starts_blk3", starts, 3);
    chk("op_n_after_rst", o_core_n, opv(4));
    chk("op_d_stall", o_core_d, opv(1));
    chk("op_a_stall", o_core_a, opv(2));
    chk_tx(62, "tx_blk3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
